nn_output_fifo: RTL and testbench

- Result-side buffer for the wishbone neural-network block; the counterpart of the input buffer. The NN core pushes 32-bit result words through a valid/ready handshake. The wishbone slave drains them with single-word classic read cycles.
- Sits between the NN datapath output and the wishbone read-data mux. Address decode is external.
- Storage is a circular buffer with an exact occupancy count, and simultaneous push/pop is supported.

---
 rtl/nn_output_fifo_if.sv | 36 +++
 rtl/nn_output_fifo.sv | 120 ++++++++++++
 tb/tb_nn_output_fifo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/nn_output_fifo_if.sv
// Result-side handshake and wishbone read bundle for nn_output_fifo.
// master: NN core plus bus decode; slave: the FIFO.
// Optional sticky error flags appear when NN_OUT_FIFO_FLAGS_EN is defined.
interface nn_output_fifo_if #(
  parameter int unsigned AW = 3
);
  logic          res_valid;
  logic [31:0]   res_data;
  logic          res_ready;
  logic          rd_stb;
  logic          rd_ack;
  logic [31:0]   rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
`ifdef NN_OUT_FIFO_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  modport master (
    output res_valid, res_data, rd_stb,
    input  res_ready, rd_ack, rd_data, empty, full, count
`ifdef NN_OUT_FIFO_FLAGS_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  res_valid, res_data, rd_stb,
    output res_ready, rd_ack, rd_data, empty, full, count
`ifdef NN_OUT_FIFO_FLAGS_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/nn_output_fifo.sv
// Result buffer between the NN datapath and the wishbone read-data mux.
// Circular buffer with exact occupancy count; NN core pushes via valid/ready,
// bus drains one word per two-cycle classic read (IDLE -> ACK).
// Empty reads return zero and still acknowledge.
// Optional: define NN_OUT_FIFO_FLAGS_EN for sticky overflow/underflow outputs.
module nn_output_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input logic            clk,
  input logic            rst,
  nn_output_fifo_if.slave bus
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef enum logic {StIdle, StAck} state_e;

  state_e          state_q;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            rd_ack_q;
  logic [31:0]     rd_data_q;

  logic empty, full, push, rd_accept, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FullCount);
  assign push      = bus.res_valid && !full;
  assign rd_accept = (state_q == StIdle) && bus.rd_stb;
  assign pop       = rd_accept && !empty;

  // Next pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.res_data;
  end

  // Read FSM with registered ack and data; data holds outside ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          rd_ack_q <= 1'b0;
          if (bus.rd_stb) begin
            state_q   <= StAck;
            rd_ack_q  <= 1'b1;
            rd_data_q <= empty ? 32'h0 : mem_q[rd_ptr_q];
          end
        end
        StAck: begin
          state_q  <= StIdle;
          rd_ack_q <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          rd_ack_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef NN_OUT_FIFO_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.res_valid && full) overflow_q  <= 1'b1;
      if (rd_accept && empty)    underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

  assign bus.res_ready = !full;
  assign bus.rd_ack    = rd_ack_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_nn_output_fifo.sv
// Directed bench for nn_output_fifo: a vector table for basic push/read
// traffic, then hand sequences for full/overflow, concurrent push+pop with
// pointer wrap, and asynchronous reset during an acknowledge.
module tb_nn_output_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nn_output_fifo_if #(.AW(3)) bus ();

  nn_output_fifo #(.DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        stb;
    logic        ack;
    logic [31:0] rdata;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.res_data  = d;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
  endtask

  // One full read: IDLE->ACK edge checked, then ACK->IDLE edge consumed.
  task automatic read_word(input string name, input logic [31:0] exp);
    @(negedge clk);
    bus.rd_stb = 1'b1;
    @(posedge clk);
    #1;
    chk({name, "_ack"}, {31'h0, bus.rd_ack}, 32'h1);
    chk({name, "_data"}, bus.rd_data, exp);
    bus.rd_stb = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dw [8];
    logic [31:0] ew [3];

    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.rd_stb    = 1'b0;

    // Basic traffic; expectations are the state after each edge.
    tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0};
    tbl[1]  = '{1'b1, 32'hA0000001, 1'b0, 1'b0, 32'h0,        4'd1};
    tbl[2]  = '{1'b1, 32'hA0000002, 1'b0, 1'b0, 32'h0,        4'd2};
    tbl[3]  = '{1'b1, 32'hA0000003, 1'b0, 1'b0, 32'h0,        4'd3};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA0000001, 4'd2};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hA0000001, 4'd2};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA0000002, 4'd1};
    tbl[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 32'hA0000002, 4'd1};
    tbl[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA0000003, 4'd0};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hA0000003, 4'd0};
    tbl[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        4'd0};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd0};
    tbl[12] = '{1'b1, 32'hB0000001, 1'b1, 1'b1, 32'h0,        4'd1};
    tbl[13] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'd1};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hB0000001, 4'd0};
    tbl[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'hB0000001, 4'd0};

    for (int i = 0; i < 8; i++) dw[i] = 32'hD0000000 + 32'(i);
    for (int i = 0; i < 3; i++) ew[i] = 32'hE0000000 + 32'(i);

    // Reset, then idle three cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
    chk("rst_full", {31'h0, bus.full}, 32'h0);
    chk("rst_count", {28'h0, bus.count}, 32'h0);
    chk("rst_ready", {31'h0, bus.res_ready}, 32'h1);
    chk("rst_ack", {31'h0, bus.rd_ack}, 32'h0);
    chk("rst_data", bus.rd_data, 32'h0);

    // Table-driven basic traffic.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.res_valid = tbl[i].valid;
      bus.res_data  = tbl[i].data;
      bus.rd_stb    = tbl[i].stb;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_ack", i), {31'h0, bus.rd_ack}, {31'h0, tbl[i].ack});
      chk($sformatf("v%0d_data", i), bus.rd_data, tbl[i].rdata);
      chk($sformatf("v%0d_count", i), {28'h0, bus.count}, {28'h0, tbl[i].cnt});
      chk($sformatf("v%0d_empty", i), {31'h0, bus.empty}, {31'h0, tbl[i].cnt == 4'd0});
      chk($sformatf("v%0d_full", i), {31'h0, bus.full}, {31'h0, tbl[i].cnt == 4'd8});
    end
    bus.res_valid = 1'b0;
    bus.rd_stb    = 1'b0;
`ifdef NN_OUT_FIFO_FLAGS_EN
    chk("underflow_set", {31'h0, bus.underflow}, 32'h1);
    chk("overflow_clear", {31'h0, bus.overflow}, 32'h0);
`endif

    // Fill to full, try a ninth word, then drain in order.
    for (int i = 0; i < 8; i++) push_word(32'hC0000000 + 32'(i));
    chk("fill_full", {31'h0, bus.full}, 32'h1);
    chk("fill_ready", {31'h0, bus.res_ready}, 32'h0);
    chk("fill_count", {28'h0, bus.count}, 32'h8);
    push_word(32'hDEADBEEF);
    chk("ovf_count", {28'h0, bus.count}, 32'h8);
`ifdef NN_OUT_FIFO_FLAGS_EN
    chk("overflow_set", {31'h0, bus.overflow}, 32'h1);
`endif
    for (int i = 0; i < 8; i++) read_word($sformatf("drain%0d", i), 32'hC0000000 + 32'(i));
    chk("drain_count", {28'h0, bus.count}, 32'h0);
    chk("drain_empty", {31'h0, bus.empty}, 32'h1);

    // Full, then concurrent push+pop for six cycles; pushes land only in ACK cycles.
    for (int i = 0; i < 8; i++) push_word(dw[i]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.res_valid = 1'b1;
      bus.res_data  = ew[c/2];
      bus.rd_stb    = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("sim%0d_count", c), {28'h0, bus.count}, (c % 2 == 0) ? 32'h7 : 32'h8);
      chk($sformatf("sim%0d_ack", c), {31'h0, bus.rd_ack}, (c % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("sim%0d_data", c), bus.rd_data, dw[c/2]);
    end
    bus.res_valid = 1'b0;
    bus.rd_stb    = 1'b0;
    for (int i = 3; i < 8; i++) read_word($sformatf("wrap_d%0d", i), dw[i]);
    for (int i = 0; i < 3; i++) read_word($sformatf("wrap_e%0d", i), ew[i]);
    chk("wrap_count", {28'h0, bus.count}, 32'h0);

    // Asynchronous reset while an ACK is pending with four words buffered.
    for (int i = 0; i < 4; i++) push_word(32'hF0000000 + 32'(i));
    chk("pre_rst_count", {28'h0, bus.count}, 32'h4);
    @(negedge clk);
    bus.rd_stb = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_ack", {31'h0, bus.rd_ack}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ack", {31'h0, bus.rd_ack}, 32'h0);
    chk("arst_count", {28'h0, bus.count}, 32'h0);
    chk("arst_empty", {31'h0, bus.empty}, 32'h1);
    #1;
    rst = 1'b0;
    bus.rd_stb = 1'b0;
`ifdef NN_OUT_FIFO_FLAGS_EN
    chk("arst_ovf", {31'h0, bus.overflow}, 32'h0);
`endif
    read_word("post_rst", 32'h0);
    chk("post_rst_count", {28'h0, bus.count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
